// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_pkg
// Brief   : Shared state encoding and sizing helpers for the sequential divider
// Rev     : 1.0
// ============================================================================
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value N itself, hence N+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_add_sub.sv
`default_nettype none
// ============================================================================
// Module  : add_subBar
// Brief   : W-bit adder/subtractor; add_sub=1 gives a-b with cout = not-borrow
// Rev     : 1.0
// ============================================================================
module add_subBar #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add_sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;

  // Two's-complement subtract: invert b and feed add_sub in as the carry-in.
  assign b_eff       = add_sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, add_sub};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : N-bit unsigned restoring divider, one quotient bit per clock
// Rev     : 1.0
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = cnt_width(N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]       rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     dvsr_q, dvsr_d;
  logic [N-1:0]     quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [N:0]       shifted;
  logic [N:0]       diff;
  logic             no_borrow;
  logic             accept;
  logic             unused_rem_msb;

  // After a restoring step the partial remainder is below the divisor, so its MSB is never shifted out.
  assign unused_rem_msb = rem_q[N];
  assign shifted        = {rem_q[N-1:0], quo_q[N-1]};

  add_subBar #(
    .W (N + 1)
  ) u_trial_sub (
    .a       (shifted),
    .b       ({1'b0, dvsr_q}),
    .add_sub (1'b1),
    .sum     (diff),
    .cout    (no_borrow)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    accept      = start && (state_q != CALC);

    case (state_q)
      CALC: begin
        rem_d = no_borrow ? diff : shifted;
        quo_d = {quo_q[N-2:0], no_borrow};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          quotient_d  = quo_d;
          remainder_d = rem_d[N-1:0];
        end
      end
      default: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (divisor == '0) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = dividend;
          dbz_d       = 1'b1;
        end else begin
          state_d = CALC;
          rem_d   = '0;
          quo_d   = dividend;
          dvsr_d  = divisor;
          cnt_d   = CNT_W'(N);
          dbz_d   = 1'b0;
        end
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
